// File: rtl/scr1_trace_pkg.sv
// scr1_trace_pkg: shared types and constants for the trace-event scheduler.
//   type_scr1_trace_rec_e  record type carried on the output stream
//   type_scr1_trace_rec_s  one buffered/emitted trace record
//   type_scr1_trace_fsm_e  scheduler capture state
//   SCR1_TRACE_CSR_*       CSR index encoding of csr_upd_idx
package scr1_trace_pkg;

  typedef enum logic [1:0] {
    MPRF = 2'd0,
    CSR  = 2'd1,
    LOSS = 2'd2
  } type_scr1_trace_rec_e;

  typedef struct packed {
    type_scr1_trace_rec_e rec_type;
    logic [4:0]           tag;
    logic [31:0]          data;
  } type_scr1_trace_rec_s;

  typedef enum logic [1:0] {
    TRC_OFF   = 2'd0,
    TRC_RUN   = 2'd1,
    TRC_DRAIN = 2'd2
  } type_scr1_trace_fsm_e;

  localparam logic [2:0] SCR1_TRACE_CSR_MSTATUS  = 3'd0;
  localparam logic [2:0] SCR1_TRACE_CSR_MTVEC    = 3'd1;
  localparam logic [2:0] SCR1_TRACE_CSR_MIE      = 3'd2;
  localparam logic [2:0] SCR1_TRACE_CSR_MIP      = 3'd3;
  localparam logic [2:0] SCR1_TRACE_CSR_MEPC     = 3'd4;
  localparam logic [2:0] SCR1_TRACE_CSR_MCAUSE   = 3'd5;
  localparam logic [2:0] SCR1_TRACE_CSR_MBADADDR = 3'd6;
  localparam logic [2:0] SCR1_TRACE_CSR_RSVD     = 3'd7;

  // x0 writes carry no information and are never traced
  localparam logic [4:0] SCR1_TRACE_MPRF_X0 = 5'd0;

endpackage

// File: rtl/scr1_trace_fifo.sv
// scr1_trace_fifo: small synchronous FIFO of trace records, no bypass.
//   clk, rst_n  clock, asynchronous active-low reset (empties the FIFO)
//   push        write push_rec; taken when not full, or when full and popped
//   push_rec    record to write
//   pop         drop the head entry (ignored when empty)
//   full/empty  occupancy flags
//   head        oldest entry (valid when !empty)
module scr1_trace_fifo
  import scr1_trace_pkg::*;
#(
  parameter int DEPTH = 4
)(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  type_scr1_trace_rec_s push_rec,
  input  logic                 pop,
  output logic                 full,
  output logic                 empty,
  output type_scr1_trace_rec_s head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  type_scr1_trace_rec_s mem_r [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_r;
  logic [PTR_W-1:0]     rd_ptr_r;
  logic [CNT_W-1:0]     cnt_r;
  logic                 pop_s;
  logic                 wr_s;

  assign full  = (cnt_r == CNT_W'(DEPTH));
  assign empty = (cnt_r == '0);
  assign head  = mem_r[rd_ptr_r];

  // a pop frees the slot in the same cycle, so a full FIFO still accepts
  assign pop_s = pop & ~empty;
  assign wr_s  = push & (~full | pop_s);

  // storage array; contents are don't-care while unoccupied
  always_ff @(posedge clk) begin
    if (wr_s) begin
      mem_r[wr_ptr_r] <= push_rec;
    end
  end

  // pointers and occupancy; pointers wrap naturally (DEPTH is a power of 2)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      cnt_r    <= '0;
    end else begin
      if (wr_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({wr_s, pop_s})
        2'b10:   cnt_r <= cnt_r + CNT_W'(1);
        2'b01:   cnt_r <= cnt_r - CNT_W'(1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

endmodule

// File: rtl/scr1_trace_sched.sv
// scr1_trace_sched: captures MPRF write-back and CSR update events into two
// FIFOs and merges them round-robin onto one valid/ready record stream.
// Overflows are counted (drop_cnt) and reported in-band by a LOSS record.
//   trc_en                   capture enable (level, registered effect)
//   mprf_wr_*                MPRF write-back events (x0 ignored)
//   csr_upd_*                CSR update events (index 7 ignored)
//   out_vld/out_rdy          output handshake; fields held while stalled
//   out_type/out_tag/out_data  record contents
//   drop_cnt                 saturating count of dropped events since reset
//   busy                     scheduler is not OFF
module scr1_trace_sched
  import scr1_trace_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int DROP_CNT_W = 8
)(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  trc_en,
  input  logic                  mprf_wr_en,
  input  logic [4:0]            mprf_wr_addr,
  input  logic [31:0]           mprf_wr_data,
  input  logic                  csr_upd_en,
  input  logic [2:0]            csr_upd_idx,
  input  logic [31:0]           csr_upd_data,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic [1:0]            out_type,
  output logic [4:0]            out_tag,
  output logic [31:0]           out_data,
  output logic [DROP_CNT_W-1:0] drop_cnt,
  output logic                  busy
);

  // saturating add of 0..2 drops to a counter
  function automatic logic [DROP_CNT_W-1:0] sat_add(input logic [DROP_CNT_W-1:0] base,
                                                    input logic [1:0]            inc);
    logic [DROP_CNT_W:0] sum;
    sum = {1'b0, base} + {{(DROP_CNT_W-1){1'b0}}, inc};
    if (sum[DROP_CNT_W]) begin
      sat_add = '1;
    end else begin
      sat_add = sum[DROP_CNT_W-1:0];
    end
  endfunction

  type_scr1_trace_fsm_e state_r, state_nxt_s;
  logic                 capture_s, busy_nxt_s, busy_r;
  type_scr1_trace_rec_s mprf_rec_s, csr_rec_s, mprf_head_s, csr_head_s;
  type_scr1_trace_rec_s out_rec_r, out_rec_nxt_s;
  logic                 out_vld_r, out_vld_nxt_s;
  logic                 mprf_full_s, mprf_empty_s, csr_full_s, csr_empty_s;
  logic                 mprf_req_s, csr_req_s, mprf_push_s, csr_push_s;
  logic                 mprf_drop_s, csr_drop_s;
  logic [1:0]           drop_inc_s;
  logic                 load_s, gnt_loss_s, gnt_mprf_s, gnt_csr_s;
  logic                 last_grant_csr_r;
  logic [DROP_CNT_W-1:0] loss_pend_r, drop_cnt_r;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= TRC_OFF;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= busy_nxt_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      TRC_OFF: begin
        if (trc_en) state_nxt_s = TRC_RUN;
        else        state_nxt_s = TRC_OFF;
      end
      TRC_RUN: begin
        if (!trc_en) state_nxt_s = TRC_DRAIN;
        else         state_nxt_s = TRC_RUN;
      end
      TRC_DRAIN: begin
        if (trc_en) begin
          state_nxt_s = TRC_RUN;
        end else if (mprf_empty_s && csr_empty_s && (loss_pend_r == '0) && !out_vld_r) begin
          state_nxt_s = TRC_OFF;
        end else begin
          state_nxt_s = TRC_DRAIN;
        end
      end
      default: state_nxt_s = TRC_OFF;
    endcase
  end

  // FSM outputs: capture only in RUN; busy follows the next state so it is registered
  always_comb begin
    capture_s  = 1'b0;
    busy_nxt_s = 1'b1;
    case (state_r)
      TRC_RUN: capture_s = 1'b1;
      default: capture_s = 1'b0;
    endcase
    if (state_nxt_s == TRC_OFF) busy_nxt_s = 1'b0;
    else                        busy_nxt_s = 1'b1;
  end

  // capture qualification and drop detection
  always_comb begin
    mprf_req_s  = capture_s & mprf_wr_en & (mprf_wr_addr != SCR1_TRACE_MPRF_X0);
    csr_req_s   = capture_s & csr_upd_en & (csr_upd_idx != SCR1_TRACE_CSR_RSVD);
    mprf_push_s = mprf_req_s & (~mprf_full_s | gnt_mprf_s);
    csr_push_s  = csr_req_s & (~csr_full_s | gnt_csr_s);
    mprf_drop_s = mprf_req_s & ~mprf_push_s;
    csr_drop_s  = csr_req_s & ~csr_push_s;
    drop_inc_s  = {1'b0, mprf_drop_s} + {1'b0, csr_drop_s};
    mprf_rec_s  = '{rec_type: MPRF, tag: mprf_wr_addr, data: mprf_wr_data};
    csr_rec_s   = '{rec_type: CSR, tag: {2'b00, csr_upd_idx}, data: csr_upd_data};
  end

  // arbiter: pending loss first, then round-robin between non-empty FIFOs
  always_comb begin
    load_s     = ~out_vld_r | out_rdy;
    gnt_loss_s = 1'b0;
    gnt_mprf_s = 1'b0;
    gnt_csr_s  = 1'b0;
    if (!load_s) begin
      gnt_loss_s = 1'b0;
    end else if (loss_pend_r != '0) begin
      gnt_loss_s = 1'b1;
    end else if (!mprf_empty_s && !csr_empty_s) begin
      if (last_grant_csr_r) gnt_mprf_s = 1'b1;
      else                  gnt_csr_s  = 1'b1;
    end else if (!mprf_empty_s) begin
      gnt_mprf_s = 1'b1;
    end else if (!csr_empty_s) begin
      gnt_csr_s = 1'b1;
    end else begin
      gnt_loss_s = 1'b0;
    end
  end

  // next output-register contents
  always_comb begin
    out_rec_nxt_s = out_rec_r;
    out_vld_nxt_s = out_vld_r;
    if (load_s) begin
      out_vld_nxt_s = gnt_loss_s | gnt_mprf_s | gnt_csr_s;
      if (gnt_loss_s) begin
        out_rec_nxt_s = '{rec_type: LOSS, tag: 5'd0, data: 32'(loss_pend_r)};
      end else if (gnt_mprf_s) begin
        out_rec_nxt_s = mprf_head_s;
      end else if (gnt_csr_s) begin
        out_rec_nxt_s = csr_head_s;
      end else begin
        out_rec_nxt_s = out_rec_r;
      end
    end else begin
      out_vld_nxt_s = out_vld_r;
    end
  end

  // output register, round-robin pointer and loss/drop counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_rec_r        <= '0;
      out_vld_r        <= 1'b0;
      last_grant_csr_r <= 1'b1;
      loss_pend_r      <= '0;
      drop_cnt_r       <= '0;
    end else begin
      out_rec_r  <= out_rec_nxt_s;
      out_vld_r  <= out_vld_nxt_s;
      drop_cnt_r <= sat_add(drop_cnt_r, drop_inc_s);
      if (gnt_mprf_s || gnt_csr_s) begin
        last_grant_csr_r <= gnt_csr_s;
      end
      // drops in the emitting cycle start a fresh pending count
      if (gnt_loss_s) begin
        loss_pend_r <= sat_add('0, drop_inc_s);
      end else begin
        loss_pend_r <= sat_add(loss_pend_r, drop_inc_s);
      end
    end
  end

  scr1_trace_fifo #(.DEPTH(FIFO_DEPTH)) u_mprf_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (mprf_push_s),
    .push_rec (mprf_rec_s),
    .pop      (gnt_mprf_s),
    .full     (mprf_full_s),
    .empty    (mprf_empty_s),
    .head     (mprf_head_s)
  );

  scr1_trace_fifo #(.DEPTH(FIFO_DEPTH)) u_csr_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (csr_push_s),
    .push_rec (csr_rec_s),
    .pop      (gnt_csr_s),
    .full     (csr_full_s),
    .empty    (csr_empty_s),
    .head     (csr_head_s)
  );

  assign out_vld  = out_vld_r;
  assign out_type = out_rec_r.rec_type;
  assign out_tag  = out_rec_r.tag;
  assign out_data = out_rec_r.data;
  assign drop_cnt = drop_cnt_r;
  assign busy     = busy_r;

endmodule
